// File: rtl/conv_phase_sequencer.sv
// conv_phase_sequencer
//   Steps a NUM_STATES-state phase counter (one state per kernel tap) through
//   a programmable number of passes. Each state lasts SUB_DIV clock cycles,
//   tracked by a sub-phase counter on the single system clock. A start/busy/done
//   handshake frames each run; hold stalls the counters and abort ends a run.
//   The line-buffer/MAC array uses state_out/sub_phase as the tap select and
//   the pulses as accumulate/flush strobes.
//
// Ports
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   start               run request, sampled only while idle
//   num_passes          passes to run, latched when start is accepted
//   hold                stall: freezes counters and FSM
//   abort               ends a run on the next edge with no completion pulses
//   state_out           current phase state, 0..NUM_STATES-1
//   sub_phase           cycle index within the current state
//   pass_idx            0-based index of the current pass
//   busy                high while running
//   final_state_reached one-cycle pulse at (NUM_STATES-1, FINAL_SUB) each pass
//   pass_done           one-cycle pulse on the first cycle after each pass
//   done                one-cycle pulse on normal completion of a run
module conv_phase_sequencer #(
  parameter int NUM_STATES = 9,
  parameter int STATE_W    = 4,
  parameter int SUB_DIV    = 4,
  parameter int SUB_W      = 2,
  parameter int FINAL_SUB  = 1,
  parameter int PASS_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [PASS_W-1:0] num_passes,
  input  logic              hold,
  input  logic              abort,
  output logic [STATE_W-1:0] state_out,
  output logic [SUB_W-1:0]  sub_phase,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              final_state_reached,
  output logic              pass_done,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);
  localparam logic [SUB_W-1:0]   LAST_SUB   = SUB_W'(SUB_DIV - 1);
  localparam logic [SUB_W-1:0]   FIRE_SUB   = SUB_W'(FINAL_SUB);

  fsm_t               fsm, fsm_nx;
  logic [PASS_W-1:0]  passes_q, passes_nx;
  logic [STATE_W-1:0] state_nx;
  logic [SUB_W-1:0]   sub_nx;
  logic [PASS_W-1:0]  pass_nx;
  logic               busy_nx, final_nx, pass_done_nx, done_nx;

  // Every output is computed here as a next value and registered below, so
  // no input reaches an output combinationally. Pulses default to 0, which is
  // what makes them self-clear after one cycle, including during hold.
  always_comb begin
    fsm_nx       = fsm;
    passes_nx    = passes_q;
    state_nx     = state_out;
    sub_nx       = sub_phase;
    pass_nx      = pass_idx;
    busy_nx      = busy;
    final_nx     = 1'b0;
    pass_done_nx = 1'b0;
    done_nx      = 1'b0;

    case (fsm)
      IDLE: begin
        state_nx = '0;
        sub_nx   = '0;
        pass_nx  = '0;
        busy_nx  = 1'b0;
        if (start && !abort) begin
          passes_nx = num_passes;
          if (num_passes == '0) begin
            // Zero-length run: report completion without any busy cycles.
            fsm_nx  = DONE;
            done_nx = 1'b1;
          end else begin
            fsm_nx  = RUN;
            busy_nx = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          fsm_nx   = IDLE;
          state_nx = '0;
          sub_nx   = '0;
          pass_nx  = '0;
          busy_nx  = 1'b0;
        end else if (!hold) begin
          if (sub_phase == LAST_SUB) begin
            sub_nx = '0;
            if (state_out == LAST_STATE) begin
              state_nx     = '0;
              pass_done_nx = 1'b1;
              if (pass_idx == passes_q - PASS_W'(1)) begin
                fsm_nx  = DONE;
                pass_nx = '0;
                busy_nx = 1'b0;
                done_nx = 1'b1;
              end else begin
                pass_nx = pass_idx + PASS_W'(1);
              end
            end else begin
              state_nx = state_out + STATE_W'(1);
            end
          end else begin
            sub_nx = sub_phase + SUB_W'(1);
          end
          // Only an advancing edge can load the firing position, so a held
          // (8,FINAL_SUB) position never re-issues the pulse.
          final_nx = (state_nx == LAST_STATE) && (sub_nx == FIRE_SUB);
        end
      end

      DONE: begin
        fsm_nx   = IDLE;
        state_nx = '0;
        sub_nx   = '0;
        pass_nx  = '0;
        busy_nx  = 1'b0;
      end

      default: begin
        fsm_nx   = IDLE;
        state_nx = '0;
        sub_nx   = '0;
        pass_nx  = '0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm                 <= IDLE;
      passes_q            <= '0;
      state_out           <= '0;
      sub_phase           <= '0;
      pass_idx            <= '0;
      busy                <= 1'b0;
      final_state_reached <= 1'b0;
      pass_done           <= 1'b0;
      done                <= 1'b0;
    end else begin
      fsm                 <= fsm_nx;
      passes_q            <= passes_nx;
      state_out           <= state_nx;
      sub_phase           <= sub_nx;
      pass_idx            <= pass_nx;
      busy                <= busy_nx;
      final_state_reached <= final_nx;
      pass_done           <= pass_done_nx;
      done                <= done_nx;
    end
  end

endmodule

// File: tb/tb_conv_phase_sequencer.sv
// Testbench for conv_phase_sequencer: a default-parameter instance checked
// every cycle against a run-cycle-count reference model, plus a second
// instance with NUM_STATES=4, SUB_DIV=1, FINAL_SUB=0.
module tb_conv_phase_sequencer;

  localparam int NS = 9;
  localparam int SD = 4;
  localparam int FS = 1;
  localparam int PP = NS * SD;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       start1 = 1'b0, hold1 = 1'b0, abort1 = 1'b0;
  logic [7:0] np1 = '0;
  logic [3:0] state1;
  logic [1:0] sub1;
  logic [7:0] pass1;
  logic       busy1, fin1, pd1, done1;

  logic       start2 = 1'b0, hold2 = 1'b0, abort2 = 1'b0;
  logic [7:0] np2 = '0;
  logic [1:0] state2;
  logic [0:0] sub2;
  logic [7:0] pass2;
  logic       busy2, fin2, pd2, done2;

  always #5 clk = ~clk;

  conv_phase_sequencer u_dut (
    .clk(clk), .reset_n(reset_n), .start(start1), .num_passes(np1),
    .hold(hold1), .abort(abort1), .state_out(state1), .sub_phase(sub1),
    .pass_idx(pass1), .busy(busy1), .final_state_reached(fin1),
    .pass_done(pd1), .done(done1)
  );

  conv_phase_sequencer #(
    .NUM_STATES(4), .STATE_W(2), .SUB_DIV(1), .SUB_W(1), .FINAL_SUB(0), .PASS_W(8)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .num_passes(np2),
    .hold(hold2), .abort(abort2), .state_out(state2), .sub_phase(sub2),
    .pass_idx(pass2), .busy(busy2), .final_state_reached(fin2),
    .pass_done(pd2), .done(done2)
  );

  // Observed outputs packed as {state[3:0], sub[1:0], pass[7:0], busy, final, pass_done, done}.
  logic [17:0] act1, act2;
  assign act1 = {state1, sub1, pass1, busy1, fin1, pd1, done1};
  assign act2 = {2'b00, state2, 1'b0, sub2, pass2, busy2, fin2, pd2, done2};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: tracks how many run cycles have elapsed and derives
  // every output from that count with plain arithmetic.
  int          m_mode = 0;   // 0 idle, 1 running, 2 completion cycle
  int          m_t = 0;
  int          m_total = 0;
  logic [17:0] exp_vec = '0;

  function automatic logic [17:0] pack(input int st, input int sb, input int ps,
                                       input bit b, input bit f, input bit pd, input bit d);
    logic [3:0] stv;
    logic [1:0] sbv;
    logic [7:0] psv;
    stv = 4'(st);
    sbv = 2'(sb);
    psv = 8'(ps);
    return {stv, sbv, psv, b, f, pd, d};
  endfunction

  function automatic logic [17:0] run_view(input int t);
    int i;
    i = t % PP;
    return pack(i / SD, i % SD, t / PP, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic modelEdge(input bit s, input int np, input bit h, input bit a);
    int i;
    case (m_mode)
      1: begin
        if (a) begin
          m_mode  = 0;
          exp_vec = '0;
        end else if (h) begin
          exp_vec = run_view(m_t);
        end else begin
          m_t = m_t + 1;
          if (m_t == m_total) begin
            m_mode  = 2;
            exp_vec = pack(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
          end else begin
            i = m_t % PP;
            exp_vec = pack(i / SD, i % SD, m_t / PP, 1'b1,
                           i == (NS - 1) * SD + FS, i == 0, 1'b0);
          end
        end
      end
      2: begin
        m_mode  = 0;
        exp_vec = '0;
      end
      default: begin
        if (s && !a) begin
          if (np == 0) begin
            m_mode  = 2;
            exp_vec = pack(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
          end else begin
            m_mode  = 1;
            m_t     = 0;
            m_total = np * PP;
            exp_vec = run_view(0);
          end
        end else begin
          exp_vec = '0;
        end
      end
    endcase
  endtask

  task automatic checkVec(input string name, input logic [17:0] got, input logic [17:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  task automatic checkOutput(input string name);
    checkVec(name, act1, exp_vec);
  endtask

  // Drives one cycle of inputs into the selected instance (the other sees
  // idle inputs), then checks the default instance against the model.
  task automatic applyStimulus(input bit sel, input bit s, input logic [7:0] np,
                               input bit h, input bit a);
    @(negedge clk);
    start1 = sel ? 1'b0 : s;  np1 = sel ? 8'd0 : np;
    hold1  = sel ? 1'b0 : h;  abort1 = sel ? 1'b0 : a;
    start2 = sel ? s : 1'b0;  np2 = sel ? np : 8'd0;
    hold2  = sel ? h : 1'b0;  abort2 = sel ? a : 1'b0;
    @(posedge clk);
    #1;
    if (sel) modelEdge(1'b0, 0, 1'b0, 1'b0);
    else     modelEdge(s, int'(np), h, a);
    checkOutput("model");
  endtask

  // Starts a run and observes ncycles further cycles; cycle 0 is the first
  // run cycle. Optional hold window, abort cycle and mid-run start cycle
  // refer to the cycle during which the input is high (-1 disables).
  task automatic runScenario(input int np, input int hold_from, input int hold_len,
                             input int abort_at, input int start_mid_at, input int ncycles,
                             output int busy_cnt, output int fin_cnt, output int fin_first,
                             output int done_cnt, output int done_cyc,
                             output int pd_cnt, output int pd_last);
    bit h, a, s;
    busy_cnt = 0; fin_cnt = 0; fin_first = -1; done_cnt = 0;
    done_cyc = -1; pd_cnt = 0; pd_last = -1;
    applyStimulus(1'b0, 1'b1, 8'(np), 1'b0, 1'b0);
    for (int c = 0; c <= ncycles; c++) begin
      if (c > 0) begin
        h = (hold_from >= 0) && (c - 1 >= hold_from) && (c - 1 < hold_from + hold_len);
        a = (c - 1 == abort_at);
        s = (c - 1 == start_mid_at);
        applyStimulus(1'b0, s, s ? 8'd7 : 8'd0, h, a);
      end
      if (busy1) busy_cnt++;
      if (fin1) begin
        fin_cnt++;
        if (fin_first < 0) fin_first = c;
      end
      if (done1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (pd1) begin
        pd_cnt++;
        pd_last = c;
      end
    end
  endtask

  typedef struct {
    bit          sel;
    bit          start;
    logic [7:0]  np;
    bit          hold;
    bit          abort;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int bc, fc, ff, dc, dy, pc, pl;
    int pulse_hits;

    vecs[0]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, pack(0, 0, 0, 0, 0, 0, 1)};
    vecs[1]  = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b0, pack(0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b1, pack(0, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{1'b0, 1'b1, 8'd1, 1'b0, 1'b0, pack(0, 0, 0, 1, 0, 0, 0)};
    vecs[4]  = '{1'b0, 1'b1, 8'd5, 1'b0, 1'b0, pack(0, 1, 0, 1, 0, 0, 0)};
    vecs[5]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, pack(0, 1, 0, 1, 0, 0, 0)};
    vecs[6]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, pack(0, 2, 0, 1, 0, 0, 0)};
    vecs[7]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, pack(0, 0, 0, 0, 0, 0, 0)};
    vecs[8]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, pack(0, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{1'b1, 1'b1, 8'd1, 1'b0, 1'b0, pack(0, 0, 0, 1, 0, 0, 0)};
    vecs[10] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, pack(1, 0, 0, 1, 0, 0, 0)};
    vecs[11] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, pack(2, 0, 0, 1, 0, 0, 0)};
    vecs[12] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, pack(3, 0, 0, 1, 1, 0, 0)};
    vecs[13] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, pack(0, 0, 0, 0, 0, 1, 1)};
    vecs[14] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, pack(0, 0, 0, 0, 0, 0, 0)};

    repeat (3) @(posedge clk);
    #1;
    checkVec("reset_dut1", act1, '0);
    checkVec("reset_dut2", act2, '0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] table vectors");
    for (int k = 0; k < 15; k++) begin
      applyStimulus(vecs[k].sel, vecs[k].start, vecs[k].np, vecs[k].hold, vecs[k].abort);
      checkVec($sformatf("vec%0d", k), vecs[k].sel ? act2 : act1, vecs[k].exp);
    end

    $display("[TB] single pass");
    runScenario(1, -1, 0, -1, -1, 40, bc, fc, ff, dc, dy, pc, pl);
    checkValue("p1_busy_cycles", bc, 36);
    checkValue("p1_final_count", fc, 1);
    checkValue("p1_final_cycle", ff, 33);
    checkValue("p1_done_cycle", dy, 36);
    checkValue("p1_pass_done_cycle", pl, 36);

    $display("[TB] three passes with mid-run start");
    runScenario(3, -1, 0, -1, 50, 112, bc, fc, ff, dc, dy, pc, pl);
    checkValue("p3_busy_cycles", bc, 108);
    checkValue("p3_final_count", fc, 3);
    checkValue("p3_done_count", dc, 1);
    checkValue("p3_done_cycle", dy, 108);
    checkValue("p3_pass_done_count", pc, 3);
    checkValue("p3_pass_done_last", pl, 108);

    $display("[TB] hold across final state");
    runScenario(1, 33, 5, -1, -1, 45, bc, fc, ff, dc, dy, pc, pl);
    checkValue("hold_final_count", fc, 1);
    checkValue("hold_final_cycle", ff, 33);
    checkValue("hold_done_cycle", dy, 41);

    $display("[TB] abort near end of pass");
    runScenario(1, -1, 0, 35, -1, 40, bc, fc, ff, dc, dy, pc, pl);
    checkValue("abort_busy_cycles", bc, 36);
    checkValue("abort_done_count", dc, 0);
    checkValue("abort_pass_done_count", pc, 0);
    runScenario(1, -1, 0, -1, -1, 40, bc, fc, ff, dc, dy, pc, pl);
    checkValue("restart_busy_cycles", bc, 36);
    checkValue("restart_done_cycle", dy, 36);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    checkVec("async_reset", act1, '0);
    m_mode = 0;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    $display("[TB] randomized stimulus");
    pulse_hits = 0;
    for (int c = 0; c < 2500; c++) begin
      applyStimulus(1'b0, ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 3)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0));
      if (fin1 || pd1 || done1) pulse_hits++;
    end
    n_checks++;
    if (pulse_hits > 0) n_pass++;
    else $display("[TB] FAIL random_pulses: got %0d pulse cycles expected more than 0", pulse_hits);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_phase_sequencer.md
Name: conv_phase_sequencer

Overview:
- Parametrised successor to the fixed 9-state window sequencer. It steps a K-state phase counter (default 9, one state per 3x3 kernel tap) through a programmable number of passes.
- Each state lasts SUB_DIV clock cycles. A single-clock sub-phase counter replaces the old second-clock 2-bit divider.
- Adds start/busy/done handshake, hold (stall), abort, a pass counter and per-pass pulses.
- Sits between the convolution controller and the line-buffer/MAC array, which consume state_out and sub_phase as tap select and the pulses as accumulate/flush strobes.

Parameters:
- NUM_STATES, 9, states per pass (2..16); state_out counts 0..NUM_STATES-1.
- STATE_W, 4, width of state_out; must satisfy 2^STATE_W >= NUM_STATES.
- SUB_DIV, 4, clk cycles per state (1..16).
- SUB_W, 2, width of sub_phase; 2^SUB_W >= SUB_DIV (min 1).
- FINAL_SUB, 1, sub_phase index (0..SUB_DIV-1) at which final_state_reached fires in the last state.
- PASS_W, 8, width of num_passes and pass_idx.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a run; sampled only in IDLE.
- num_passes  input  PASS_W  passes to run; latched on start acceptance.
- hold  input  1  stall: freezes all counters while high.
- abort  input  1  terminate a run immediately.
- state_out  output  STATE_W  current phase state.
- sub_phase  output  SUB_W  cycle index within the current state.
- pass_idx  output  PASS_W  index of the current pass (0-based).
- busy  output  1  high while in RUN.
- final_state_reached  output  1  one-cycle pulse per pass (see below).
- pass_done  output  1  one-cycle pulse at the end of each pass.
- done  output  1  one-cycle pulse at normal completion of a run.

Behaviour:
- Reset (reset_n low, async): FSM=IDLE. All outputs 0. Latched passes register 0.
- All outputs are registered. No input-to-output combinational path.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with num_passes!=0 and abort=0: latch num_passes, go to RUN on that edge.
  - In the first RUN cycle: state_out=0, sub_phase=0, pass_idx=0, busy=1.
  - start with num_passes=0: go to DONE directly (done pulses next cycle, no RUN cycles).
- RUN, per edge with hold=0 and abort=0:
  - sub_phase increments. At SUB_DIV-1 it wraps to 0 and state_out increments.
  - At state_out=NUM_STATES-1 with sub_phase=SUB_DIV-1 (end of pass): state_out wraps to 0 and pass_idx increments.
  - If pass_idx was latched_passes-1 at end of pass, go to DONE instead.
- Run timing: run length = num_passes*NUM_STATES*SUB_DIV cycles. Cycle i of a pass has state_out=i/SUB_DIV and sub_phase=i%SUB_DIV.
- final_state_reached:
  - Set on the edge that loads state_out=NUM_STATES-1 and sub_phase=FINAL_SUB.
  - Cleared on the following edge regardless of hold; exactly one pulse per pass.
- pass_done:
  - Set on the edge leaving the last cycle of a pass, i.e. coincident with (0,0) of the next pass or with the DONE cycle.
  - Cleared on the following edge.
- DONE: one cycle. done=1, busy=0, state_out=0, sub_phase=0, pass_idx=0. Then IDLE. start is ignored in the DONE cycle.
- hold=1 in RUN: counters, pass_idx and FSM frozen. Pulses still self-clear after one cycle and are not re-issued when hold drops.
- abort=1 in RUN or DONE:
  - Next edge forces IDLE with all outputs 0.
  - No done or pass_done is issued, even if the edge coincides with end of pass.
- Priorities: abort > hold > normal advance. In IDLE, abort with start means start is ignored. start during RUN is ignored (no restart).
- SUB_DIV=1: sub_phase is held at 0, state advances every cycle, FINAL_SUB must be 0.

Test Plan:
- Defaults, start with num_passes=1 -> busy for 36 cycles; final_state_reached only at run cycle 33 (state_out=8, sub_phase=1); at cycle 36 done=1, pass_done=1, busy=0; IDLE at cycle 37.
- num_passes=3 -> 108 busy cycles; pass_done at cycles 36, 72 and 108; pass_idx reads 0, 1, 2; three final_state_reached pulses (cycles 33, 69, 105); a single done at cycle 108.
- hold high for 5 cycles starting at run cycle 33 -> final_state_reached high only at cycle 33; state (8,1) held until cycle 38; done at cycle 41.
- abort at run cycle 35 of a single-pass run -> IDLE next cycle, all outputs 0, no done or pass_done; a new start then runs a normal 36 cycles.
- start with num_passes=0 -> done pulses the next cycle, busy never rises. start asserted mid-run -> ignored.
- reset_n pulsed low mid-run (asynchronous, between edges) -> all outputs 0 immediately. Parameter set NUM_STATES=4, SUB_DIV=1, FINAL_SUB=0 with one pass -> 4 busy cycles, final_state_reached at cycle 3, done at cycle 4.
